// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock controller:
// FSM state encoding, display glyph codes and digit helpers.
package lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  // Button vector layout: [3:0] = up1..up4, then store, then check.
  localparam int NUM_BTN   = 6;
  localparam int BTN_STORE = 4;
  localparam int BTN_CHECK = 5;

  localparam logic [DIGIT_W-1:0] GLYPH_PASS = 4'd10;
  localparam logic [DIGIT_W-1:0] GLYPH_FAIL = 4'd11;
  localparam logic [DIGIT_W-1:0] GLYPH_LOCK = 4'd12;

  typedef enum logic [2:0] {
    SETUP   = 3'd0,
    LOCKED  = 3'd1,
    OPEN    = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd9) ? '0 : d + 4'd1;
  endfunction

  // Every digit with a press bumps independently, so simultaneous presses all land.
  function automatic digits_t bump_digits(input digits_t d, input logic [NUM_DIGITS-1:0] p);
    digits_t r;
    r = d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (p[i]) r[i] = digit_inc(d[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_tick_gen.sv
// Slow tick prescaler plus per-button rising-edge detection; buttons are
// only sampled on tick, so a held button produces a single press.
module lock_tick_gen #(
  parameter int TICK_DIV = 16777216,
  parameter int NUM_BTN  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  output logic               tick,
  output logic [NUM_BTN-1:0] press
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   cnt;
  logic [NUM_BTN-1:0] prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      prev <= '0;
    end else if (tick) begin
      cnt  <= '0;
      prev <= btn;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick  = (cnt == CNT_MAX);
  assign press = tick ? (btn & ~prev) : '0;

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Combination-lock sequencing FSM: digit entry, key enrollment, compare, fail counting
// and lockout. Define LOCK_AUTO_RELOCK_EN to add an idle auto-relock timeout in OPEN.
module lock_ctrl_fsm
  import lock_pkg::*;
#(
  parameter int TICK_DIV      = 16777216,
  parameter int MAX_FAIL      = 3,
  parameter int FAIL_TICKS    = 4,
  parameter int LOCKOUT_TICKS = 16,
  parameter int RELOCK_TICKS  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            up1,
  input  logic                            up2,
  input  logic                            up3,
  input  logic                            up4,
  input  logic                            store,
  input  logic                            check,
  output logic [DIGIT_W-1:0]              d0,
  output logic [DIGIT_W-1:0]              d1,
  output logic [DIGIT_W-1:0]              d2,
  output logic [DIGIT_W-1:0]              d3,
  output logic [2:0]                      state,
  output logic                            unlock,
  output logic                            alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  // Timer is shared by every timed state, so it is sized for the longest dwell.
  localparam int TMR_MAX_A = (FAIL_TICKS > LOCKOUT_TICKS) ? FAIL_TICKS : LOCKOUT_TICKS;
  localparam int TMR_MAX   = (TMR_MAX_A > RELOCK_TICKS) ? TMR_MAX_A : RELOCK_TICKS;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  // Loads are dwell-1 because the exit happens on the tick that sees zero.
  localparam logic [TMR_W-1:0] FAIL_LOAD    = TMR_W'(FAIL_TICKS - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_TICKS - 1);
`ifdef LOCK_AUTO_RELOCK_EN
  localparam logic [TMR_W-1:0] RELOCK_LOAD  = TMR_W'(RELOCK_TICKS - 1);
`endif

  logic               tick;
  logic [NUM_BTN-1:0] press;

  lock_state_t         state_q, state_n;
  digits_t             dig_q, dig_n;
  digits_t             key_q, key_n;
  logic [FAIL_W-1:0]   fail_q, fail_n;
  logic [TMR_W-1:0]    timer_q, timer_n;

  lock_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .NUM_BTN  (NUM_BTN)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .btn   ({check, store, up4, up3, up2, up1}),
    .tick  (tick),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SETUP;
      dig_q   <= '0;
      key_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      dig_q   <= dig_n;
      key_q   <= key_n;
      fail_q  <= fail_n;
      timer_q <= timer_n;
    end
  end

  // Within a tick, check outranks store which outranks up; a lower-priority
  // press is dropped even when the higher one is ignored in the current state.
  always_comb begin
    state_n = state_q;
    dig_n   = dig_q;
    key_n   = key_q;
    fail_n  = fail_q;
    timer_n = timer_q;

    case (state_q)
      SETUP: begin
        if (tick && !press[BTN_CHECK]) begin
          if (press[BTN_STORE]) begin
            key_n   = dig_q;
            dig_n   = '0;
            state_n = LOCKED;
          end else begin
            dig_n = bump_digits(dig_q, press[NUM_DIGITS-1:0]);
          end
        end
      end

      LOCKED: begin
        if (tick) begin
          if (press[BTN_CHECK]) begin
            if (dig_q == key_q) begin
              state_n = OPEN;
              dig_n   = {NUM_DIGITS{GLYPH_PASS}};
              fail_n  = '0;
`ifdef LOCK_AUTO_RELOCK_EN
              timer_n = RELOCK_LOAD;
`endif
            end else if (int'(fail_q) + 1 < MAX_FAIL) begin
              state_n = FAIL;
              dig_n   = {NUM_DIGITS{GLYPH_FAIL}};
              fail_n  = fail_q + 1'b1;
              timer_n = FAIL_LOAD;
            end else begin
              state_n = LOCKOUT;
              dig_n   = {NUM_DIGITS{GLYPH_LOCK}};
              fail_n  = FAIL_W'(MAX_FAIL);
              timer_n = LOCKOUT_LOAD;
            end
          end else if (!press[BTN_STORE]) begin
            dig_n = bump_digits(dig_q, press[NUM_DIGITS-1:0]);
          end
        end
      end

      OPEN: begin
        if (tick) begin
          if (press[BTN_CHECK]) begin
            dig_n   = '0;
            state_n = LOCKED;
          end else if (press[BTN_STORE]) begin
            dig_n   = '0;
            state_n = SETUP;
          end
`ifdef LOCK_AUTO_RELOCK_EN
          else if (|press) begin
            timer_n = RELOCK_LOAD;
          end else if (timer_q == '0) begin
            dig_n   = '0;
            state_n = LOCKED;
          end else begin
            timer_n = timer_q - 1'b1;
          end
`endif
        end
      end

      FAIL: begin
        if (tick) begin
          if (timer_q == '0) begin
            dig_n   = '0;
            state_n = LOCKED;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
      end

      LOCKOUT: begin
        if (tick) begin
          if (timer_q == '0) begin
            dig_n   = '0;
            fail_n  = '0;
            state_n = LOCKED;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
      end

      default: begin
        state_n = SETUP;
        dig_n   = '0;
        timer_n = '0;
      end
    endcase
  end

  assign d0       = dig_q[0];
  assign d1       = dig_q[1];
  assign d2       = dig_q[2];
  assign d3       = dig_q[3];
  assign state    = state_q;
  assign unlock   = (state_q == OPEN);
  assign alarm    = (state_q == LOCKOUT);
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Self-checking bench for lock_ctrl_fsm: directed scenarios plus random button traffic,
// all checked every cycle against a tick-level behavioural model of the lock.
module tb_lock_ctrl_fsm;
  import lock_pkg::*;

  localparam int TICK_DIV      = 4;
  localparam int MAX_FAIL      = 3;
  localparam int FAIL_TICKS    = 4;
  localparam int LOCKOUT_TICKS = 16;
  localparam int RELOCK_TICKS  = 8;
  localparam int FW            = $clog2(MAX_FAIL + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic up1 = 1'b0, up2 = 1'b0, up3 = 1'b0, up4 = 1'b0, store = 1'b0, check = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic [2:0] state;
  logic unlock, alarm;
  logic [FW-1:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  lock_ctrl_fsm #(
    .TICK_DIV      (TICK_DIV),
    .MAX_FAIL      (MAX_FAIL),
    .FAIL_TICKS    (FAIL_TICKS),
    .LOCKOUT_TICKS (LOCKOUT_TICKS),
    .RELOCK_TICKS  (RELOCK_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up1      (up1),
    .up2      (up2),
    .up3      (up3),
    .up4      (up4),
    .store    (store),
    .check    (check),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .state    (state),
    .unlock   (unlock),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  // Behavioural model: counts clocks since reset, and on every TICK_DIV-th clock
  // applies one tick's worth of the lock rules to a display array and a key array.
  lock_state_t m_state;
  int          m_dig[4];
  int          m_key[4];
  int          m_fail;
  int          m_left;
  int          m_cyc;
  logic [5:0]  m_prev;

  always @(posedge clk) begin : model
    lock_state_t s;
    int          d[4];
    int          k[4];
    int          f;
    int          left;
    logic [5:0]  b;
    logic [5:0]  pr;
    bit          match;
    if (!reset) begin
      m_state <= SETUP;
      m_dig   <= '{0, 0, 0, 0};
      m_key   <= '{0, 0, 0, 0};
      m_fail  <= 0;
      m_left  <= 0;
      m_cyc   <= 0;
      m_prev  <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc % TICK_DIV) == TICK_DIV - 1) begin
        b  = {check, store, up4, up3, up2, up1};
        pr = b & ~m_prev;
        m_prev <= b;
        s = m_state; d = m_dig; k = m_key; f = m_fail; left = m_left;
        case (s)
          SETUP, LOCKED: begin
            if (pr[5]) begin
              if (s == LOCKED) begin
                match = 1'b1;
                for (int i = 0; i < 4; i++) if (d[i] != k[i]) match = 1'b0;
                if (match) begin
                  s = OPEN; d = '{10, 10, 10, 10}; f = 0; left = RELOCK_TICKS;
                end else if (f + 1 < MAX_FAIL) begin
                  s = FAIL; d = '{11, 11, 11, 11}; f = f + 1; left = FAIL_TICKS;
                end else begin
                  s = LOCKOUT; d = '{12, 12, 12, 12}; f = MAX_FAIL; left = LOCKOUT_TICKS;
                end
              end
            end else if (pr[4]) begin
              if (s == SETUP) begin
                k = d; d = '{0, 0, 0, 0}; s = LOCKED;
              end
            end else begin
              for (int i = 0; i < 4; i++) if (pr[i]) d[i] = (d[i] + 1) % 10;
            end
          end
          OPEN: begin
            if (pr[5]) begin
              s = LOCKED; d = '{0, 0, 0, 0};
            end else if (pr[4]) begin
              s = SETUP; d = '{0, 0, 0, 0};
            end else begin
`ifdef LOCK_AUTO_RELOCK_EN
              if (pr != 0) begin
                left = RELOCK_TICKS;
              end else begin
                left = left - 1;
                if (left == 0) begin s = LOCKED; d = '{0, 0, 0, 0}; end
              end
`endif
            end
          end
          FAIL, LOCKOUT: begin
            left = left - 1;
            if (left == 0) begin
              if (s == LOCKOUT) f = 0;
              s = LOCKED; d = '{0, 0, 0, 0};
            end
          end
          default: s = SETUP;
        endcase
        m_state <= s; m_dig <= d; m_key <= k; m_fail <= f; m_left <= left;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle after the first reset edge, the DUT must agree with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("d0", int'(d0), m_dig[0]);
      checkOutput("d1", int'(d1), m_dig[1]);
      checkOutput("d2", int'(d2), m_dig[2]);
      checkOutput("d3", int'(d3), m_dig[3]);
      checkOutput("state", int'(state), int'(m_state));
      checkOutput("unlock", int'(unlock), (m_state == OPEN) ? 1 : 0);
      checkOutput("alarm", int'(alarm), (m_state == LOCKOUT) ? 1 : 0);
      checkOutput("fail_cnt", int'(fail_cnt), m_fail);
    end
  end

  // Hold a button mask for whole tick periods, then release for one tick, so
  // exactly one tick sees the rising edge regardless of prescaler phase.
  task automatic applyStimulus(input logic [5:0] mask, input int hold_ticks);
    @(negedge clk);
    {check, store, up4, up3, up2, up1} = mask;
    repeat (hold_ticks * TICK_DIV) @(negedge clk);
    {check, store, up4, up3, up2, up1} = '0;
    repeat (TICK_DIV) @(negedge clk);
  endtask

  task automatic pressN(input logic [5:0] mask, input int n);
    for (int i = 0; i < n; i++) applyStimulus(mask, 1);
  endtask

  task automatic checkDigits(input string name, input int e0, input int e1, input int e2, input int e3);
    checkOutput({name, "_d0"}, int'(d0), e0);
    checkOutput({name, "_d1"}, int'(d1), e1);
    checkOutput({name, "_d2"}, int'(d2), e2);
    checkOutput({name, "_d3"}, int'(d3), e3);
  endtask

  // Press check and return how many clocks the chosen status output stayed high.
  task automatic measureHigh(input bit use_alarm, output int cycles);
    int guard;
    cycles = 0;
    guard  = 0;
    @(negedge clk);
    check = 1'b1;
    while (((use_alarm ? alarm : unlock) !== 1'b1) && guard < 4 * TICK_DIV) begin
      @(negedge clk);
      guard++;
    end
    check = 1'b0;
    while (((use_alarm ? alarm : unlock) === 1'b1) && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int cyc;
    int n;
    int r;
    logic [5:0] mask;

    // Reset held for three clocks.
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("lit_reset_state", int'(state), int'(SETUP));
    checkDigits("lit_reset", 0, 0, 0, 0);
    checkOutput("lit_reset_fail", int'(fail_cnt), 0);
    reset = 1'b1;

    // Enroll key 2,0,5,0.
    pressN(6'b000001, 2);
    pressN(6'b000100, 5);
    checkDigits("lit_entry", 2, 0, 5, 0);
    applyStimulus(6'b010000, 1);
    checkOutput("lit_enroll_state", int'(state), int'(LOCKED));
    checkDigits("lit_enroll", 0, 0, 0, 0);

    // Correct entry opens, check relocks.
    pressN(6'b000001, 2);
    pressN(6'b000100, 5);
    applyStimulus(6'b100000, 1);
    checkDigits("lit_open", 10, 10, 10, 10);
    checkOutput("lit_open_unlock", int'(unlock), 1);
    checkOutput("lit_open_fail", int'(fail_cnt), 0);
    applyStimulus(6'b100000, 1);
    checkOutput("lit_relock_state", int'(state), int'(LOCKED));
    checkOutput("lit_relock_unlock", int'(unlock), 0);
    checkDigits("lit_relock", 0, 0, 0, 0);

    // Two failures, then lockout for exactly LOCKOUT_TICKS ticks.
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(6'b100000, 1);
      checkDigits("lit_fail", 11, 11, 11, 11);
      checkOutput("lit_fail_cnt", int'(fail_cnt), i);
      repeat (FAIL_TICKS * TICK_DIV) @(negedge clk);
      checkDigits("lit_after_fail", 0, 0, 0, 0);
      checkOutput("lit_after_fail_state", int'(state), int'(LOCKED));
    end
    measureHigh(1'b1, cyc);
    checkOutput("lit_lockout_cycles", cyc, LOCKOUT_TICKS * TICK_DIV);
    checkOutput("lit_lockout_exit_state", int'(state), int'(LOCKED));
    checkOutput("lit_lockout_exit_fail", int'(fail_cnt), 0);

    // Wrap of d1 and a held up4.
    pressN(6'b000010, 3);
    checkOutput("lit_d1_three", int'(d1), 3);
    pressN(6'b000010, 7);
    checkOutput("lit_d1_wrap", int'(d1), 0);
    applyStimulus(6'b001000, 5);
    checkOutput("lit_held_up4", int'(d3), 1);

    // check + up1 together on a wrong code: FAIL wins, up1 is dropped.
    applyStimulus(6'b100001, 1);
    checkOutput("lit_prio_state", int'(state), int'(FAIL));
    checkOutput("lit_prio_fail", int'(fail_cnt), 1);
    repeat (FAIL_TICKS * TICK_DIV) @(negedge clk);
    checkDigits("lit_prio_after", 0, 0, 0, 0);

    // Reach lockout again, then reset in the middle of it.
    applyStimulus(6'b100000, 1);
    repeat (FAIL_TICKS * TICK_DIV) @(negedge clk);
    applyStimulus(6'b100000, 1);
    checkOutput("lit_lockout_alarm", int'(alarm), 1);
    checkDigits("lit_lockout", 12, 12, 12, 12);
    checkOutput("lit_lockout_fail", int'(fail_cnt), MAX_FAIL);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("lit_midreset_state", int'(state), int'(SETUP));
    checkOutput("lit_midreset_alarm", int'(alarm), 0);
    reset = 1'b1;

    // Enroll 0,0,0,0 and open; observe OPEN duration.
    applyStimulus(6'b010000, 1);
`ifdef LOCK_AUTO_RELOCK_EN
    measureHigh(1'b0, cyc);
    checkOutput("lit_autorelock_cycles", cyc, RELOCK_TICKS * TICK_DIV);
    checkOutput("lit_autorelock_state", int'(state), int'(LOCKED));
`else
    applyStimulus(6'b100000, 1);
    repeat (100 * TICK_DIV) @(negedge clk);
    checkOutput("lit_open_hold_state", int'(state), int'(OPEN));
    checkOutput("lit_open_hold_unlock", int'(unlock), 1);
    applyStimulus(6'b100000, 1);
`endif

    // Random traffic, with occasional correct entries and resets.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r < 12)       mask = 6'(1 << (r % 4));
      else if (r < 14)  mask = 6'($urandom_range(1, 15));
      else if (r < 16)  mask = 6'b010000;
      else if (r < 19)  mask = 6'b100000;
      else              mask = 6'($urandom_range(1, 63));
      applyStimulus(mask, $urandom_range(1, 2));
      if ($urandom_range(0, 7) == 0 && m_state == LOCKED) begin
        for (int i = 0; i < 4; i++) begin
          n = (m_key[i] - m_dig[i] + 10) % 10;
          pressN(6'(1 << i), n);
        end
        applyStimulus(6'b100000, 1);
      end
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
